// File: rtl/btn_gesture_if.sv
// rtl/btn_gesture_if.sv - debounced button events in, gesture command pulses out
interface btn_gesture_if;
    logic i_press;
    logic i_release;
    logic i_state;
    logic o_short;
    logic o_double;
    logic o_long;
    logic o_held;
    logic o_busy;

    modport master (
        output i_press, i_release, i_state,
        input  o_short, o_double, o_long, o_held, o_busy
    );

    modport slave (
        input  i_press, i_release, i_state,
        output o_short, o_double, o_long, o_held, o_busy
    );
endinterface

// File: rtl/btn_gesture.sv
// rtl/btn_gesture.sv - classifies button gestures into short / double / long command pulses
module btn_gesture #(
    parameter int LONG_CYC   = 100_000_000,
    parameter int DCLICK_CYC = 30_000_000,
    parameter int CNT_W      = 27
) (
    input  logic          clk,
    input  logic          rst,
    btn_gesture_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG,
        LOCKOUT
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             short_q;
    logic             double_q;
    logic             long_q;
    logic             held_q;
    logic             busy_q;
    logic             short_d;
    logic             double_d;
    logic             long_d;
    logic             ev_press;
    logic             ev_release;
    logic             counting;

    // Simultaneous press and release carry no usable meaning, so both are dropped.
    assign ev_press   = bus.i_press & ~bus.i_release;
    assign ev_release = bus.i_release & ~bus.i_press;
    assign counting   = (state_q == PRESS1) || (state_q == WAIT2) || (state_q == PRESS2);

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A press landing on the cycle the short pulse goes out belongs to the closed gesture.
                if (ev_press && !short_q) begin
                    state_d = PRESS1;
                end else if (bus.i_state) begin
                    state_d = LOCKOUT;
                end
            end
            PRESS1: begin
                if (ev_release) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (ev_press) begin
                    state_d = PRESS2;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (ev_release) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    short_d = 1'b1;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
                if (ev_release) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (!bus.i_state && !bus.i_press) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            held_q   <= (state_d == LONG);
            busy_q   <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (counting && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.o_short  = short_q;
    assign bus.o_double = double_q;
    assign bus.o_long   = long_q;
    assign bus.o_held   = held_q;
    assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_btn_gesture.sv
// tb/tb_btn_gesture.sv - randomized and directed bench for btn_gesture against a timestamp model
module tb_btn_gesture;
    localparam int LONG_CYC   = 20;
    localparam int DCLICK_CYC = 10;
    localparam int CNT_W      = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btn_gesture_if bus();

    btn_gesture #(
        .LONG_CYC   (LONG_CYC),
        .DCLICK_CYC (DCLICK_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int gcyc     = 0;
    logic lvl_prev = 1'b0;

    // Reference: gesture phase plus the cycle it was entered; elapsed time is plain subtraction.
    int   m_phase = 0;
    int   m_enter = 0;
    logic e_short = 0, e_double = 0, e_long = 0, e_held = 0, e_busy = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, gcyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic r_v, input logic p, input logic r, input logic st);
        int   nxt;
        int   age;
        logic s, d, l, ep, er;
        if (r_v) begin
            m_phase = 0;
            {e_short, e_double, e_long, e_held, e_busy} = '0;
            return;
        end
        ep  = p && !r;
        er  = r && !p;
        age = gcyc - m_enter;
        nxt = m_phase;
        s = 0; d = 0; l = 0;
        case (m_phase)
            0: if (ep && !e_short) nxt = 1; else if (st) nxt = 5;
            1: if (er) nxt = 2; else if (age == LONG_CYC - 1) begin nxt = 4; l = 1; end
            2: if (ep) nxt = 3; else if (age == DCLICK_CYC - 1) begin nxt = 0; s = 1; end
            3: if (er) begin nxt = 0; d = 1; end
               else if (age == LONG_CYC - 1) begin nxt = 4; s = 1; l = 1; end
            4: if (er) nxt = 0;
            default: if (!st && !p) nxt = 0;
        endcase
        if (nxt != m_phase) m_enter = gcyc + 1;
        m_phase  = nxt;
        e_short  = s;
        e_double = d;
        e_long   = l;
        e_held   = (m_phase == 4);
        e_busy   = (m_phase != 0);
    endtask

    task automatic drive(input logic level, input logic rst_v, input logic bad);
        bus.i_press   = level & ~lvl_prev;
        bus.i_release = ~level & lvl_prev;
        bus.i_state   = lvl_prev;
        if (bad) begin
            bus.i_press   = 1'b1;
            bus.i_release = 1'b1;
        end
        rst = rst_v;
        model_edge(rst_v, bus.i_press, bus.i_release, bus.i_state);
        @(posedge clk);
        #1;
        gcyc++;
        check("outputs", {27'd0, bus.o_short, bus.o_double, bus.o_long, bus.o_held, bus.o_busy},
              {27'd0, e_short, e_double, e_long, e_held, e_busy});
        lvl_prev = level;
    endtask

    task automatic run_dir(input string tag, input logic pre, input int a0, input int a1,
                           input int b0, input int b1, input int es, input int ed,
                           input int el, input int eh);
        int   f_s, f_d, f_l, f_h;
        logic held_seen;
        logic lvl;
        f_s = -1; f_d = -1; f_l = -1; f_h = -1;
        held_seen = 0;
        for (int i = 0; i < 3; i++) drive(pre, 1'b1, 1'b0);
        check({tag, "_reset"}, {27'd0, bus.o_short, bus.o_double, bus.o_long, bus.o_held, bus.o_busy}, 0);
        for (int c = 0; c < 60; c++) begin
            lvl = (pre && c < 10) || (c >= a0 && c < a1) || (c >= b0 && c < b1);
            drive(lvl, 1'b0, 1'b0);
            if (bus.o_short  && f_s < 0) f_s = c + 1;
            if (bus.o_double && f_d < 0) f_d = c + 1;
            if (bus.o_long   && f_l < 0) f_l = c + 1;
            if (bus.o_held) held_seen = 1;
            else if (held_seen && f_h < 0) f_h = c + 1;
            if (pre && c + 1 == 5) check({tag, "_lockout_busy"}, {31'd0, bus.o_busy}, 1);
        end
        check({tag, "_short_cyc"},  f_s, es);
        check({tag, "_double_cyc"}, f_d, ed);
        check({tag, "_long_cyc"},   f_l, el);
        check({tag, "_heldfall"},   f_h, eh);
    endtask

    initial begin
        int   dur;
        logic lvl;
        bus.i_press = 0;
        bus.i_release = 0;
        bus.i_state = 0;

        run_dir("short",     1'b0, 5, 9,  0,  0,  20, -1, -1, -1);
        run_dir("long",      1'b0, 5, 40, 0,  0,  -1, -1, 26, 41);
        run_dir("double",    1'b0, 5, 8,  12, 15, -1, 16, -1, -1);
        run_dir("win_edge",  1'b0, 5, 8,  18, 20, -1, 21, -1, -1);
        run_dir("win_after", 1'b0, 5, 8,  19, 21, 19, -1, -1, -1);
        run_dir("dbl_hold",  1'b0, 5, 8,  12, 40, 33, -1, 33, 41);
        run_dir("lockout",   1'b1, 20, 23, 0, 0,  34, -1, -1, -1);

        lvl = 0;
        for (int seg = 0; seg < 300; seg++) begin
            lvl = ~lvl;
            case ($urandom_range(0, 2))
                0:       dur = $urandom_range(1, 6);
                1:       dur = $urandom_range(DCLICK_CYC - 2, DCLICK_CYC + 2);
                default: dur = $urandom_range(LONG_CYC - 2, LONG_CYC + 3);
            endcase
            for (int k = 0; k < dur; k++) begin
                drive(lvl, ($urandom_range(0, 199) == 0), (k > 0) && ($urandom_range(0, 99) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/btn_gesture.md
Name: btn_gesture

Overview:
Consumes the debounced button events (press pulse, release pulse, stable level) and classifies each gesture as short press, double click or long press. It emits one-cycle command pulses to the recorder control FSM, for example start/stop record, play, or erase. It sits directly downstream of the button debouncer, one instance per button, in the same clock domain.

Parameters:
LONG_CYC, 100_000_000, cycles a press must be held to count as long (1 s at 100 MHz)
DCLICK_CYC, 30_000_000, max cycles from first release to second press for a double click (300 ms)
CNT_W, 27, counter width; must satisfy 2^CNT_W > max(LONG_CYC, DCLICK_CYC)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
i_press  in  1  one-cycle pulse: debounced press edge
i_release  in  1  one-cycle pulse: debounced release edge
i_state  in  1  debounced level; 1 = pressed; lags i_press/i_release by one cycle
o_short  out  1  one-cycle pulse: single short press classified
o_double  out  1  one-cycle pulse: double click classified
o_long  out  1  one-cycle pulse: hold reached LONG_CYC
o_held  out  1  level: high from o_long until the release
o_busy  out  1  level: state != IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset state: state=IDLE, counter=0, o_short=o_double=o_long=o_held=0, o_busy=0.
- Registered outputs: all outputs are registered. Each pulse is high for exactly one cycle, on the edge after its decision condition.
- Counter: CNT_W-bit. Cleared to 0 on every state entry. Increments by 1 each cycle while in PRESS1, WAIT2 or PRESS2. Saturates; never wraps.
- Illegal event inputs: i_press and i_release high in the same cycle are both ignored. Any event not listed for the current state is ignored.
- States:
  - IDLE:
    - i_press -> PRESS1.
    - Else if i_state=1 -> LOCKOUT. This covers a button held through reset or a missed edge.
  - PRESS1:
    - i_release -> WAIT2.
    - Else if counter==LONG_CYC-1 -> LONG, with o_long pulse and o_held<=1.
    - Release in the timeout cycle: release wins (short path).
  - WAIT2:
    - i_press -> PRESS2.
    - Else if counter==DCLICK_CYC-1 -> IDLE with o_short pulse.
    - Press in the timeout cycle: press wins (double path).
  - PRESS2:
    - i_release -> IDLE with o_double pulse.
    - Else if counter==LONG_CYC-1 -> LONG, with o_short and o_long pulsing in the same cycle and o_held<=1. The first click is reported as short; the hold as long.
    - Release in the timeout cycle: release wins.
  - LONG:
    - i_release -> IDLE, o_held<=0 on the same edge.
    - No further pulses while held.
  - LOCKOUT:
    - No outputs.
    - -> IDLE when i_state=0 and i_press=0.
- Latency, with press pulse at cycle T (PRESS1 entered at T+1, counter=0):
  - o_long high at cycle T+LONG_CYC+1 if still held.
  - With first release pulse at R and no second press: o_short high at R+DCLICK_CYC+1.
  - With second release pulse at R2: o_double high at R2+1.
- o_busy: high in every state except IDLE, including LOCKOUT.
- Reset mid-gesture: abandons the gesture with no pulse. If the button is still down, the block enters LOCKOUT via i_state on the next cycle.
- Exclusivity: at most one of o_short/o_double per gesture. o_long at most once per hold. o_held never high outside LONG.

Test Plan:
All scenarios use LONG_CYC=20, DCLICK_CYC=10; i_state follows the pulses with a one-cycle lag.
1. Reset: assert rst 3 cycles -> all outputs 0, o_busy=0. Pulse i_press at T=5 and i_release at T=9 -> o_short high exactly at cycle 20, no other pulses.
2. Long press: i_press at T=5, hold -> o_long and o_held rise at cycle 26. i_release at 40 -> o_held falls at 41; no o_short or o_double.
3. Double click: press 5, release 8, press 12, release 15 -> o_double high at 16 only; o_short never asserts.
4. Window boundaries: press 5, release 8.
   - Second press at 18 (timeout cycle) -> double path; release 20 gives o_double at 21.
   - Repeat with second press at 19 -> o_short at 19, and the press at 19 is ignored as it arrives in the transition cycle.
5. Second press held: press 5, release 8, press 12 held -> o_short and o_long together at 33, o_held=1; release at 40 -> o_held=0 at 41.
6. Held through reset: i_state=1 while rst drops -> LOCKOUT, o_busy=1, no pulses. i_state=0 -> IDLE. The next press/release then classifies normally.
